// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite signal bundle between one master/BFM and one memory slave.
// hready is the bus-level ready returned to everyone on the bus.
interface ahb_mem_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-addressed memory slave with programmable wait states and
// the two-cycle ERROR response for bad size or out-of-range address.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no data phase in progress, ready high
// ST_WAIT   | OKAY data phase stalled, counting down wait cycles
// ST_DATA   | OKAY data phase completing this cycle (write commits here)
// ST_ERR1   | first ERROR cycle, ready low, hresp high
// ST_ERR2   | second ERROR cycle, ready high, hresp high
module ahb_mem_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_mem_slave_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_W / 8));
  localparam logic [3:0] WS_CNT  = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic ready_int;
  logic accept;
  logic req_err;
  logic commit;
  logic unused_ok;

  assign ready_int = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign accept    = ready_int && bus.hsel && bus.hready && bus.htrans[1];
  assign req_err   = (bus.hsize != SIZE_OK) || (32'(bus.haddr) >= 32'(DEPTH));
  assign commit    = (state_q == ST_DATA) && write_q;

  // Burst type, protection, lock and the SEQ/NONSEQ distinction have no effect.
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    hrdata_d = '0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          addr_d  = bus.haddr;
          write_d = bus.hwrite;
          if (req_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_CNT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // A write retiring at this same edge must be visible to the read entering DATA.
    if ((state_d == ST_DATA) && !write_d) begin
      if (commit && (addr_d == addr_q)) hrdata_d = bus.hwdata;
      else                              hrdata_d = mem_q[addr_d];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[addr_q] <= bus.hwdata;
    end
  end

  assign bus.hreadyout = ready_int;
  assign bus.hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: four instances with WAIT_STATES 0..3 share one
// stimulus set, only the selected instance sees hsel.
module tb_ahb_mem_slave;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int DEP = 12;

  typedef struct packed {
    logic          rdy;
    logic          resp;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]    k;
    logic          wr;
    logic [AW-1:0] a;
    logic [2:0]    sz;
    logic [DW-1:0] wd;
    logic          err;
    logic [DW-1:0] rd;
    string         nm;
  } vec_t;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [1:0]    active;

  logic [3:0]          rdy_v;
  logic [3:0]          resp_v;
  logic [3:0][DW-1:0]  rdata_v;
  logic                cur_ready;
  logic                cur_resp;
  logic [DW-1:0]       cur_rdata;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];
  vec_t vecs [15];

  always #5 hclk = ~hclk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ahb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_mem_slave #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(k)
    ) u_dut (
      .hclk(hclk),
      .hresetn(hresetn),
      .bus(bus)
    );

    assign bus.hsel      = hsel && (active == 2'(k));
    assign bus.haddr     = haddr;
    assign bus.hwrite    = hwrite;
    assign bus.htrans    = htrans;
    assign bus.hsize     = hsize;
    assign bus.hburst    = 3'b000;
    assign bus.hprot     = 4'b0011;
    assign bus.hmastlock = 1'b0;
    assign bus.hwdata    = hwdata;
    assign bus.hready    = bus.hreadyout;
    assign rdy_v[k]      = bus.hreadyout;
    assign resp_v[k]     = bus.hresp;
    assign rdata_v[k]    = bus.hrdata;
  end

  assign cur_ready = rdy_v[active];
  assign cur_resp  = resp_v[active];
  assign cur_rdata = rdata_v[active];

  task automatic check(input string nm, input exp_t exp);
    exp_t act;
    act = {cur_ready, cur_resp, cur_rdata};
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%0b resp=%0b rdata=%08h, expected rdy=%0b resp=%0b rdata=%08h",
               nm, act.rdy, act.resp, act.rdata, exp.rdy, exp.resp, exp.rdata);
    end
  endtask

  // Single non-pipelined transfer; expected data-phase cycles are queued up front.
  task automatic xfer(input logic [1:0] k, input logic wr, input logic [AW-1:0] a,
                      input logic [2:0] sz, input logic [DW-1:0] wd,
                      input logic err, input logic [DW-1:0] rd, input string nm);
    int i;
    if (err) begin
      sb_q.push_back({1'b0, 1'b1, 32'h0});
      sb_q.push_back({1'b1, 1'b1, 32'h0});
    end else begin
      for (int w = 0; w < int'(k); w++) sb_q.push_back({1'b0, 1'b0, 32'h0});
      sb_q.push_back({1'b1, 1'b0, wr ? 32'h0 : rd});
    end
    @(posedge hclk); #1;
    active = k; hsel = 1'b1; haddr = a; hwrite = wr; htrans = 2'd2; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wd;
    i = 0;
    while (sb_q.size() > 0) begin
      @(negedge hclk);
      check($sformatf("%s[%0d]", nm, i), sb_q.pop_front());
      i++;
    end
  endtask

  initial begin
    vecs[0]  = '{2'd1, 1'b1, 4'd3,  3'd2, 32'hDEADBEEF, 1'b0, 32'h0,        "ws1_wr3"};
    vecs[1]  = '{2'd1, 1'b0, 4'd3,  3'd2, 32'h0,        1'b0, 32'hDEADBEEF, "ws1_rd3"};
    vecs[2]  = '{2'd3, 1'b0, 4'd0,  3'd2, 32'h0,        1'b0, 32'h0,        "ws3_rd0"};
    vecs[3]  = '{2'd1, 1'b1, 4'd5,  3'd0, 32'h11,       1'b1, 32'h0,        "byte_wr5"};
    vecs[4]  = '{2'd1, 1'b0, 4'd5,  3'd2, 32'h0,        1'b0, 32'h0,        "rd5_after_err"};
    vecs[5]  = '{2'd2, 1'b1, 4'd9,  3'd2, 32'hCAFEF00D, 1'b0, 32'h0,        "ws2_wr9"};
    vecs[6]  = '{2'd2, 1'b0, 4'd9,  3'd2, 32'h0,        1'b0, 32'hCAFEF00D, "ws2_rd9"};
    vecs[7]  = '{2'd0, 1'b1, 4'd11, 3'd2, 32'h5555AAAA, 1'b0, 32'h0,        "ws0_wr11"};
    vecs[8]  = '{2'd0, 1'b0, 4'd11, 3'd2, 32'h0,        1'b0, 32'h5555AAAA, "ws0_rd11"};
    vecs[9]  = '{2'd0, 1'b0, 4'd3,  3'd2, 32'h0,        1'b0, 32'h0,        "ws0_rd3"};
    vecs[10] = '{2'd2, 1'b1, 4'd12, 3'd2, 32'h77777777, 1'b1, 32'h0,        "wr_oob12"};
    vecs[11] = '{2'd3, 1'b0, 4'd1,  3'd3, 32'h0,        1'b1, 32'h0,        "rd_dword"};
    vecs[12] = '{2'd2, 1'b0, 4'd12, 3'd2, 32'h0,        1'b1, 32'h0,        "rd_oob12"};
    vecs[13] = '{2'd3, 1'b1, 4'd0,  3'd2, 32'hFFFFFFFF, 1'b0, 32'h0,        "ws3_wr0"};
    vecs[14] = '{2'd3, 1'b0, 4'd0,  3'd2, 32'h0,        1'b0, 32'hFFFFFFFF, "ws3_rd0b"};

    hresetn = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'd0;
    hsize = 3'd2; hwdata = '0; active = 2'd0;
    repeat (2) @(posedge hclk);
    for (int k = 0; k < 4; k++) begin
      active = 2'(k); #1;
      check($sformatf("reset_state%0d", k), {1'b1, 1'b0, 32'h0});
    end
    @(negedge hclk) hresetn = 1'b1;

    for (int v = 0; v < 15; v++)
      xfer(vecs[v].k, vecs[v].wr, vecs[v].a, vecs[v].sz, vecs[v].wd,
           vecs[v].err, vecs[v].rd, vecs[v].nm);

    // Back-to-back write then read of the same word with zero wait states.
    @(posedge hclk); #1;
    active = 2'd0; hsel = 1'b1; haddr = 4'd7; hwrite = 1'b1; htrans = 2'd2; hsize = 3'd2;
    @(posedge hclk); #1;
    haddr = 4'd7; hwrite = 1'b0; htrans = 2'd2; hwdata = 32'h0000A5A5;
    @(negedge hclk) check("pipe_wr_data", {1'b1, 1'b0, 32'h0});
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0;
    @(negedge hclk) check("pipe_rd_fwd", {1'b1, 1'b0, 32'h0000A5A5});
    xfer(2'd0, 1'b0, 4'd7, 3'd2, 32'h0, 1'b0, 32'h0000A5A5, "ws0_rd7_after_pipe");

    // Non-transfers: IDLE and BUSY with hsel, NONSEQ without hsel.
    @(posedge hclk); #1;
    active = 2'd1; hsel = 1'b1; haddr = 4'd3; hwrite = 1'b1; htrans = 2'd0; hwdata = 32'h0BADF00D;
    @(negedge hclk) check("idle_sel0", {1'b1, 1'b0, 32'h0});
    @(negedge hclk) check("idle_sel1", {1'b1, 1'b0, 32'h0});
    htrans = 2'd1;
    @(negedge hclk) check("busy_sel", {1'b1, 1'b0, 32'h0});
    hsel = 1'b0; htrans = 2'd2;
    @(negedge hclk) check("nonseq_nosel0", {1'b1, 1'b0, 32'h0});
    @(negedge hclk) check("nonseq_nosel1", {1'b1, 1'b0, 32'h0});
    htrans = 2'd0;
    xfer(2'd1, 1'b0, 4'd3, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF, "ws1_rd3_unchanged");

    // Reset dropped in the second wait cycle of a WAIT_STATES=2 write.
    @(posedge hclk); #1;
    active = 2'd2; hsel = 1'b1; haddr = 4'd2; hwrite = 1'b1; htrans = 2'd2; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h12345678;
    @(negedge hclk) check("rst_wait1", {1'b0, 1'b0, 32'h0});
    @(posedge hclk); #2;
    check("rst_wait2", {1'b0, 1'b0, 32'h0});
    hresetn = 1'b0; #1;
    check("rst_immediate", {1'b1, 1'b0, 32'h0});
    @(negedge hclk);
    @(negedge hclk) hresetn = 1'b1;
    xfer(2'd2, 1'b0, 4'd2, 3'd2, 32'h0, 1'b0, 32'h0, "rd2_after_rst");
    xfer(2'd1, 1'b0, 4'd3, 3'd2, 32'h0, 1'b0, 32'h0, "rd3_cleared_by_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
    $fatal(1);
  end
endmodule
